// File: rtl/turn_arbiter_pkg.sv
// ============================================================================
// Module : turn_arbiter_pkg
// Brief  : Shared constants, encodings and helpers for the turn arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package turn_arbiter_pkg;

  localparam int N_PLAYERS = 6;
  localparam int ID_W      = 3;

  typedef logic [ID_W-1:0]      player_id_t;
  typedef logic [N_PLAYERS-1:0] player_vec_t;
  typedef logic [1:0]           game_state_t;
  typedef logic [1:0]           lose_cause_t;

  localparam player_id_t ID_NONE    = 3'd0;
  localparam player_id_t ID_FIRST   = 3'd1;
  localparam player_id_t ID_LAST    = 3'd6;
  localparam player_id_t ID_INVALID = 3'd7;

  localparam game_state_t ST_IDLE = 2'd0;
  localparam game_state_t ST_PLAY = 2'd1;
  localparam game_state_t ST_OVER = 2'd2;

  localparam lose_cause_t CAUSE_NONE       = 2'd0;
  localparam lose_cause_t CAUSE_WRONG_TURN = 2'd1;
  localparam lose_cause_t CAUSE_ILLEGAL    = 2'd2;
  localparam lose_cause_t CAUSE_TIMEOUT    = 2'd3;

  function automatic player_vec_t id_to_onehot(input player_id_t id);
    player_vec_t v;
    for (int i = 0; i < N_PLAYERS; i++) begin
      v[i] = (id == ID_W'(i + 1));
    end
    return v;
  endfunction

  // Scanning high-to-low leaves the lowest set player as the final answer.
  function automatic player_id_t lowest_id(input player_vec_t v);
    player_id_t id;
    id = ID_NONE;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) begin
        id = ID_W'(i + 1);
      end
    end
    return id;
  endfunction

  function automatic logic is_valid_id(input player_id_t id);
    return (id >= ID_FIRST) && (id <= ID_LAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/turn_arbiter_if.sv
// ============================================================================
// Module : turn_arbiter_if
// Brief  : Game-control bundle between the player/rules side and the arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface turn_arbiter_if
  import turn_arbiter_pkg::*;
();

  logic        start;
  player_vec_t btn;
  player_id_t  next_id;
  player_id_t  cur_id;
  player_vec_t grant;
  game_state_t game_state;
  player_id_t  loser_id;
  lose_cause_t lose_cause;

  modport master (
    output start, btn, next_id,
    input  cur_id, grant, game_state, loser_id, lose_cause
  );

  modport slave (
    input  start, btn, next_id,
    output cur_id, grant, game_state, loser_id, lose_cause
  );

endinterface

`default_nettype wire

// File: rtl/turn_arbiter_btn_edge_sync.sv
// ============================================================================
// Module : turn_arbiter_btn_edge_sync
// Brief  : Button history register and registered rising-edge press vector.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_arbiter_btn_edge_sync
  import turn_arbiter_pkg::*;
(
  input  wire         clk,
  input  wire         reset,
  input  player_vec_t btn,
  output player_vec_t press
);

  player_vec_t btn_hist_q, btn_hist_d;
  player_vec_t press_q, press_d;

  always_comb begin
    btn_hist_d = btn;
    press_d    = btn & ~btn_hist_q;
  end

  // History resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_hist_q <= '1;
      press_q    <= '0;
    end else begin
      btn_hist_q <= btn_hist_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/turn_arbiter.sv
// ============================================================================
// Module : turn_arbiter
// Brief  : Turn sequencer/arbiter for the 6-player game. Optional per-turn
//          timeout is enabled by defining TURN_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module turn_arbiter
  import turn_arbiter_pkg::*;
`ifdef TURN_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 1000
)
`endif
(
  input  wire           clk,
  input  wire           reset,
  turn_arbiter_if.slave bus
);

`ifdef TURN_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0] timer_q, timer_d;
`endif

  game_state_t state_q, state_d;
  player_id_t  cur_id_q, cur_id_d;
  player_vec_t grant_q, grant_d;
  player_id_t  loser_id_q, loser_id_d;
  lose_cause_t lose_cause_q, lose_cause_d;

  player_vec_t press;
  player_vec_t cur_onehot;
  player_vec_t wrong_press;
  logic        own_press;

  turn_arbiter_btn_edge_sync u_btn_edge_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn),
    .press (press)
  );

  assign cur_onehot  = id_to_onehot(cur_id_q);
  assign wrong_press = press & ~cur_onehot;
  assign own_press   = |(press & cur_onehot);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cur_id_q     <= ID_NONE;
      grant_q      <= '0;
      loser_id_q   <= ID_NONE;
      lose_cause_q <= CAUSE_NONE;
`ifdef TURN_TIMEOUT_EN
      timer_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_id_q     <= cur_id_d;
      grant_q      <= grant_d;
      loser_id_q   <= loser_id_d;
      lose_cause_q <= lose_cause_d;
`ifdef TURN_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_id_d     = cur_id_q;
    grant_d      = '0;
    loser_id_d   = loser_id_q;
    lose_cause_d = lose_cause_q;
`ifdef TURN_TIMEOUT_EN
    timer_d      = timer_q;
`endif

    if (bus.start) begin
      state_d      = ST_PLAY;
      cur_id_d     = ID_FIRST;
      loser_id_d   = ID_NONE;
      lose_cause_d = CAUSE_NONE;
`ifdef TURN_TIMEOUT_EN
      timer_d      = '0;
`endif
    end else if (state_q == ST_PLAY) begin
      // A wrong-turn press wins even if the rightful player pressed too.
      if (|wrong_press) begin
        state_d      = ST_OVER;
        loser_id_d   = lowest_id(wrong_press);
        lose_cause_d = CAUSE_WRONG_TURN;
      end else if (own_press) begin
        if (is_valid_id(bus.next_id)) begin
          grant_d  = cur_onehot;
          cur_id_d = bus.next_id;
`ifdef TURN_TIMEOUT_EN
          timer_d  = '0;
`endif
        end else begin
          state_d      = ST_OVER;
          loser_id_d   = cur_id_q;
          lose_cause_d = CAUSE_ILLEGAL;
        end
      end else begin
`ifdef TURN_TIMEOUT_EN
        if (timer_q == TIMER_LAST) begin
          state_d      = ST_OVER;
          loser_id_d   = cur_id_q;
          lose_cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
`endif
      end
    end
  end

  always_comb begin
    bus.game_state = state_q;
    bus.cur_id     = cur_id_q;
    bus.grant      = grant_q;
    bus.loser_id   = loser_id_q;
    bus.lose_cause = lose_cause_q;
  end

endmodule

`default_nettype wire
